// File: rtl/num_code_detonator_if.sv
// rtl/num_code_detonator_if.sv - panel-side signal bundle for the numeric-code detonator
//
// Purpose: groups the debounced panel inputs and the lamp/display/blast outputs.
// Signals:
//   A[9:0]   digit keys, one-hot, bit i = digit i, high while pressed
//   ready    start code entry
//   sure     confirm entered digits
//   fire     fire request
//   setup    enter code-change mode
//   wait_t   abort to IDLE
//   m_disp   BCD of last accepted digit
//   lt/rt    entry lamp / armed lamp
//   bt/lb    blast output / alarm lamp
// Modports: master = panel side (drives keys), slave = detonator block.

interface num_code_detonator_if;
  logic [9:0] A;
  logic       ready;
  logic       sure;
  logic       fire;
  logic       setup;
  logic       wait_t;
  logic [3:0] m_disp;
  logic       lt;
  logic       rt;
  logic       bt;
  logic       lb;

  modport master (
    output A, ready, sure, fire, setup, wait_t,
    input  m_disp, lt, rt, bt, lb
  );

  modport slave (
    input  A, ready, sure, fire, setup, wait_t,
    output m_disp, lt, rt, bt, lb
  );
endinterface

// File: rtl/num_code_detonator.sv
// rtl/num_code_detonator.sv - numeric-code lock guarding a detonation output
//
// Purpose: operator presses ready, keys a 4-digit BCD code, confirms with sure.
// A matching code arms the block; fire then latches the blast output until reset.
// MAX_TRIES consecutive wrong confirms lock the panel out until reset.
// Ports:
//   clk  rising-edge system clock
//   rst  asynchronous active-low reset
//   pin  num_code_detonator_if.slave (keys/controls in, lamps/display/blast out)
// Parameters:
//   CODE       reset code, 4 BCD digits, MS digit keyed first
//   MAX_TRIES  wrong confirms before LOCK (1..7)

module num_code_detonator #(
  parameter logic [15:0] CODE      = 16'h2580,
  parameter int          MAX_TRIES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  num_code_detonator_if.slave  pin
);

  typedef enum logic [2:0] {
    IDLE, INPUT, ERROR, ARMED, SETUP, BOOM, LOCK
  } state_t;

  state_t      state, state_n;
  logic [9:0]  a_q;
  logic [15:0] entry, entry_n;
  logic [15:0] code_q, code_n;
  logic [2:0]  count, count_n;
  logic [2:0]  tries, tries_n;
  logic [2:0]  tries_inc;
  logic [3:0]  disp_q, disp_n;
  logic [9:0]  key_new;
  logic        digit_ok;
  logic [3:0]  digit;

  // Rising edges of the keys; a direct 2->5 change still yields a fresh bit.
  assign key_new  = pin.A & ~a_q;
  assign digit_ok = (key_new != 10'd0) && ((key_new & (key_new - 10'd1)) == 10'd0);

  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key_new[i]) digit = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      a_q    <= '0;
      entry  <= '0;
      code_q <= CODE;
      count  <= '0;
      tries  <= '0;
      disp_q <= '0;
    end else begin
      state  <= state_n;
      a_q    <= pin.A;
      entry  <= entry_n;
      code_q <= code_n;
      count  <= count_n;
      tries  <= tries_n;
      disp_q <= disp_n;
    end
  end

  always_comb begin
    state_n   = state;
    entry_n   = entry;
    code_n    = code_q;
    count_n   = count;
    tries_n   = tries;
    disp_n    = disp_q;
    tries_inc = tries + 3'd1;

    // Abort from any live entry/armed state; tries survive so abort cannot reset lockout.
    if (pin.wait_t && (state == INPUT || state == ERROR || state == ARMED || state == SETUP)) begin
      state_n = IDLE;
      entry_n = '0;
      count_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pin.ready) begin
            state_n = INPUT;
            entry_n = '0;
            count_n = '0;
            disp_n  = '0;
          end
        end
        INPUT: begin
          if (pin.sure) begin
            if (count == 3'd4 && entry == code_q) begin
              state_n = ARMED;
              tries_n = '0;
            end else begin
              tries_n = tries_inc;
              state_n = (tries_inc >= 3'(MAX_TRIES)) ? LOCK : ERROR;
            end
          end
        end
        ERROR: begin
          if (pin.ready) begin
            state_n = INPUT;
            entry_n = '0;
            count_n = '0;
          end
        end
        ARMED: begin
          if (pin.fire) begin
            state_n = BOOM;
          end else if (!pin.sure && pin.setup) begin
            state_n = SETUP;
            entry_n = '0;
            count_n = '0;
          end
        end
        SETUP: begin
          if (pin.sure) begin
            state_n = IDLE;
            if (count == 3'd4) code_n = entry;
          end
        end
        BOOM: state_n = BOOM;
        LOCK: state_n = LOCK;
        default: state_n = IDLE;
      endcase

      // Digits only land when no control with an effect in this state is pending.
      if ((state == INPUT || state == SETUP) && !pin.sure && digit_ok) begin
        disp_n = digit;
        if (count < 3'd4) begin
          entry_n = {entry[11:0], digit};
          count_n = count + 3'd1;
        end
      end
    end
  end

  assign pin.m_disp = disp_q;
  assign pin.lt     = (state == INPUT) || (state == SETUP);
  assign pin.rt     = (state == ARMED);
  assign pin.bt     = (state == BOOM);
  assign pin.lb     = (state == ERROR) || (state == LOCK);

endmodule

// File: tb/tb_num_code_detonator.sv
// tb/tb_num_code_detonator.sv - directed self-checking bench for num_code_detonator

module tb_num_code_detonator;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  num_code_detonator_if bus ();

  num_code_detonator #(.CODE(16'h2580), .MAX_TRIES(3)) dut (
    .clk (clk),
    .rst (rst),
    .pin (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lamps(input string tag, input logic [3:0] exp_lt_rt_bt_lb);
    chk(tag, {12'd0, bus.lt, bus.rt, bus.bt, bus.lb}, {12'd0, exp_lt_rt_bt_lb});
  endtask

  task automatic do_reset();
    bus.A = '0; bus.ready = 0; bus.sure = 0; bus.fire = 0; bus.setup = 0; bus.wait_t = 0;
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic pulse_ready();
    bus.ready = 1; step(); bus.ready = 0;
  endtask

  task automatic pulse_sure();
    bus.sure = 1; step(); bus.sure = 0;
  endtask

  // Keys digits MS first on consecutive clocks, then releases.
  task automatic key_code(input logic [15:0] c, input int ndig);
    logic [3:0] d;
    for (int i = 0; i < ndig; i++) begin
      d = c[15-4*i -: 4];
      bus.A = 10'd1 << d;
      step();
    end
    bus.A = '0;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;

    // 1) reset state
    do_reset();
    step();
    lamps("reset_lamps", 4'b0000);
    chk("reset_disp", {12'd0, bus.m_disp}, 16'd0);

    // 2) correct code then fire
    pulse_ready();
    lamps("entry_lt", 4'b1000);
    bus.A = 10'd1 << 2; step(); chk("disp_2", {12'd0, bus.m_disp}, 16'd2);
    bus.A = 10'd1 << 5; step(); chk("disp_5", {12'd0, bus.m_disp}, 16'd5);
    bus.A = 10'd1 << 8; step(); chk("disp_8", {12'd0, bus.m_disp}, 16'd8);
    bus.A = 10'd1 << 0; step(); chk("disp_0", {12'd0, bus.m_disp}, 16'd0);
    bus.A = '0; step();
    lamps("still_entry", 4'b1000);
    pulse_sure();
    lamps("armed", 4'b0100);
    bus.fire = 1; step(); bus.fire = 0;
    lamps("boom", 4'b0010);
    bus.wait_t = 1; step(); bus.wait_t = 0;
    step();
    lamps("boom_held", 4'b0010);

    // 3) wrong code, fire held is ignored
    do_reset();
    lamps("rst_clears_boom", 4'b0000);
    pulse_ready();
    key_code(16'h2581, 4);
    pulse_sure();
    lamps("wrong_err", 4'b0001);
    bus.fire = 1;
    for (int i = 0; i < 13; i++) begin
      step();
      chk("fire_held_bt", {15'd0, bus.bt}, 16'd0);
    end
    bus.fire = 0;
    lamps("err_after_fire", 4'b0001);

    // 4) lockout after three wrong confirms (short entries)
    do_reset();
    pulse_ready(); pulse_sure();
    lamps("try1_err", 4'b0001);
    pulse_ready();
    lamps("err_ready_input", 4'b1000);
    pulse_sure();
    lamps("try2_err", 4'b0001);
    pulse_ready(); pulse_sure();
    lamps("try3_lock", 4'b0001);
    pulse_ready();
    lamps("lock_ignores_ready", 4'b0001);
    bus.wait_t = 1; step(); bus.wait_t = 0;
    lamps("lock_ignores_wait", 4'b0001);
    do_reset();
    lamps("rst_clears_lock", 4'b0000);

    // 4b) double key ignored, count unchanged
    pulse_ready();
    bus.A = (10'd1 << 3) | (10'd1 << 4); step();
    chk("double_key_disp", {12'd0, bus.m_disp}, 16'd0);
    bus.A = '0; step();
    key_code(16'h2580, 4);
    pulse_sure();
    lamps("double_key_arm", 4'b0100);

    // 5) code change 2580 -> 1234
    bus.setup = 1; step(); bus.setup = 0;
    lamps("setup_lt", 4'b1000);
    key_code(16'h1234, 4);
    chk("setup_disp", {12'd0, bus.m_disp}, 16'd4);
    pulse_sure();
    lamps("setup_idle", 4'b0000);
    pulse_ready();
    key_code(16'h2580, 4);
    pulse_sure();
    lamps("old_code_rejected", 4'b0001);
    pulse_ready();
    key_code(16'h1234, 4);
    pulse_sure();
    lamps("new_code_arms", 4'b0100);
    do_reset();
    pulse_ready();
    key_code(16'h2580, 4);
    pulse_sure();
    lamps("rst_restores_code", 4'b0100);

    // 6) abort from ARMED, later fire has no effect
    bus.wait_t = 1; step(); bus.wait_t = 0;
    lamps("abort_idle", 4'b0000);
    bus.fire = 1; step(); bus.fire = 0;
    lamps("fire_in_idle", 4'b0000);

    // fifth digit shown but not stored
    pulse_ready();
    bus.A = 10'd1 << 2; step();
    bus.A = 10'd1 << 5; step();
    bus.A = 10'd1 << 8; step();
    bus.A = 10'd1 << 0; step();
    bus.A = 10'd1 << 9; step();
    chk("fifth_digit_disp", {12'd0, bus.m_disp}, 16'd9);
    bus.A = '0; step();
    pulse_sure();
    lamps("fifth_not_stored", 4'b0100);

    // short code after three digits
    bus.wait_t = 1; step(); bus.wait_t = 0;
    pulse_ready();
    key_code(16'h2580, 3);
    pulse_sure();
    lamps("short_code_err", 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
